servo_pwm_bank: RTL and testbench

//  Parametrised N-channel hobby-servo PWM generator: one shared frame counter, one pulse per channel per frame.

---
 rtl/servo_pkg.sv | 21 ++
 rtl/servo_slew_channel.sv | 64 ++++++
 rtl/servo_pwm_bank.sv | 100 ++++++++++
 tb/tb_servo_pwm_bank.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared timing defaults, angle/width types and the angle-to-pulse-width conversion
// used by every servo PWM channel.
package servo_pkg;

  localparam int unsigned DEF_FRAME_CYCLES = 1000000;
  localparam int unsigned DEF_MIN_CYCLES   = 50000;
  localparam int unsigned DEF_CYC_PER_DEG  = 275;
  localparam int unsigned DEF_MAX_ANGLE    = 180;
  localparam int unsigned DEF_ANGLE_W      = 8;
  localparam int unsigned DEF_WIDTH_W      = $clog2(DEF_FRAME_CYCLES + 1);

  typedef logic [DEF_ANGLE_W-1:0] angle_t;
  typedef logic [DEF_WIDTH_W-1:0] width_t;

  function automatic logic [31:0] angle_to_width(input logic [31:0]  angle,
                                                 input int unsigned min_cycles,
                                                 input int unsigned cyc_per_deg);
    return min_cycles + angle * cyc_per_deg;
  endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: target, slew-limited active angle and committed pulse width,
// plus the registered pulse compare against the shared frame counter.
module servo_slew_channel
  import servo_pkg::*;
#(
  parameter int unsigned ANGLE_W     = DEF_ANGLE_W,
  parameter int unsigned WIDTH_W     = DEF_WIDTH_W,
  parameter int unsigned MIN_CYCLES  = DEF_MIN_CYCLES,
  parameter int unsigned CYC_PER_DEG = DEF_CYC_PER_DEG,
  parameter int unsigned RESET_ANGLE = 90,
  parameter int unsigned SLEW_DEG    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [WIDTH_W-1:0] cnt,
  input  logic               wr_en,
  input  logic [ANGLE_W-1:0] wr_angle,
  input  logic               step_en,
  input  logic               load_en,
  output logic               servo_bit
);

  localparam logic signed [ANGLE_W:0] SLEW_LIM  = (ANGLE_W+1)'(SLEW_DEG);
  localparam logic [ANGLE_W-1:0]      RST_ANG   = ANGLE_W'(RESET_ANGLE);
  localparam logic [WIDTH_W-1:0]      RST_WIDTH =
    WIDTH_W'(angle_to_width(32'(RESET_ANGLE), MIN_CYCLES, CYC_PER_DEG));

  // Signed distance to target, saturated to +/-SLEW_LIM; result never leaves [cur, tgt].
  function automatic logic [ANGLE_W-1:0] slew_step(input logic [ANGLE_W-1:0] tgt,
                                                   input logic [ANGLE_W-1:0] cur);
    logic signed [ANGLE_W:0] diff;
    logic signed [ANGLE_W:0] nxt;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (SLEW_DEG != 0) begin
      if (diff > SLEW_LIM)       diff = SLEW_LIM;
      else if (diff < -SLEW_LIM) diff = -SLEW_LIM;
    end
    nxt = $signed({1'b0, cur}) + diff;
    return nxt[ANGLE_W-1:0];
  endfunction

  logic [ANGLE_W-1:0] target_p0;
  logic [ANGLE_W-1:0] active_p1;
  logic [WIDTH_W-1:0] width_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_p0 <= RST_ANG;
      active_p1 <= RST_ANG;
      width_p2  <= RST_WIDTH;
      servo_bit <= 1'b0;
    end else begin
      // p0: latest accepted write
      if (wr_en)   target_p0 <= wr_angle;
      // p1: one slew step per frame, two cycles before the boundary
      if (step_en) active_p1 <= slew_step(target_p0, active_p1);
      // p2: width committed on the last cycle of the frame
      if (load_en) width_p2  <= WIDTH_W'(angle_to_width(32'(active_p1), MIN_CYCLES, CYC_PER_DEG));
      servo_bit <= enable && (cnt < width_p2);
    end
  end

endmodule

// File: rtl/servo_pwm_bank.sv
// N-channel hobby-servo PWM bank: shared frame counter, angle write port with clamping,
// frame-boundary commit strobes and the per-channel pulse generators.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned ANGLE_W      = DEF_ANGLE_W,
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int unsigned MIN_CYCLES   = DEF_MIN_CYCLES,
  parameter int unsigned CYC_PER_DEG  = DEF_CYC_PER_DEG,
  parameter int unsigned MAX_ANGLE    = DEF_MAX_ANGLE,
  parameter int unsigned RESET_ANGLE  = 90,
  parameter int unsigned SLEW_DEG     = 0,
  localparam int unsigned CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [ANGLE_W-1:0] wr_angle,
  output logic [N_CH-1:0]    servo_out,
  output logic               frame_tick,
  output logic               sat_err
);

  localparam int unsigned        WIDTH_W  = $clog2(FRAME_CYCLES + 1);
  localparam logic [WIDTH_W-1:0] CNT_STEP = WIDTH_W'(FRAME_CYCLES - 2);
  localparam logic [WIDTH_W-1:0] CNT_LOAD = WIDTH_W'(FRAME_CYCLES - 1);
  localparam logic [ANGLE_W-1:0] MAX_ANG  = ANGLE_W'(MAX_ANGLE);

  if (FRAME_CYCLES < MIN_CYCLES + MAX_ANGLE * CYC_PER_DEG + 2) begin : g_bad_frame
    $error("servo_pwm_bank: FRAME_CYCLES cannot hold the longest pulse plus commit cycles");
  end
  if (MAX_ANGLE >= (1 << ANGLE_W)) begin : g_bad_angle
    $error("servo_pwm_bank: MAX_ANGLE does not fit in ANGLE_W bits");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("servo_pwm_bank: N_CH must be 1..16");
  end

  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a);
    return (a > MAX_ANG) ? MAX_ANG : a;
  endfunction

  logic [WIDTH_W-1:0] cnt_p0;
  logic               rdy_q;
  logic               step_en;
  logic               load_en;
  logic               wr_fire;
  logic [ANGLE_W-1:0] wr_angle_sat;
  logic [N_CH-1:0]    wr_en;

  // Writes are refused on the slew-step cycle so a target never changes under the commit.
  assign step_en      = enable && (cnt_p0 == CNT_STEP);
  assign load_en      = enable && (cnt_p0 == CNT_LOAD);
  assign wr_ready     = rdy_q && !step_en;
  assign wr_fire      = wr_valid && wr_ready;
  assign wr_angle_sat = clamp_angle(wr_angle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0     <= '0;
      rdy_q      <= 1'b0;
      frame_tick <= 1'b0;
      sat_err    <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      frame_tick <= enable && (cnt_p0 == '0);
      if (!enable || cnt_p0 == CNT_LOAD) cnt_p0 <= '0;
      else                               cnt_p0 <= cnt_p0 + 1'b1;
      if (wr_fire && wr_angle > MAX_ANG) sat_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_en[i] = wr_fire && (32'(wr_ch) == i);

    servo_slew_channel #(
      .ANGLE_W    (ANGLE_W),
      .WIDTH_W    (WIDTH_W),
      .MIN_CYCLES (MIN_CYCLES),
      .CYC_PER_DEG(CYC_PER_DEG),
      .RESET_ANGLE(RESET_ANGLE),
      .SLEW_DEG   (SLEW_DEG)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .cnt      (cnt_p0),
      .wr_en    (wr_en[i]),
      .wr_angle (wr_angle_sat),
      .step_en  (step_en),
      .load_en  (load_en),
      .servo_bit(servo_out[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: an unlimited-slew and a slew-limited instance share stimulus;
// a frame-level angle/width model predicts each channel's pulse length every frame.
module tb_servo_pwm_bank;

  localparam int N_CH  = 4;
  localparam int FRAME = 2000;
  localparam int MINC  = 500;
  localparam int CPD   = 5;
  localparam int MAXA  = 180;
  localparam int RSTA  = 90;

  logic       clk = 1'b0;
  logic       rst_n, enable, wr_valid;
  logic [1:0] wr_ch;
  logic [7:0] wr_angle;
  logic       wr_ready0, wr_ready1, ft0, ft1, se0, se1;
  logic [N_CH-1:0] so0, so1;

  always #5 clk = ~clk;

  servo_pwm_bank #(.N_CH(N_CH), .ANGLE_W(8), .FRAME_CYCLES(FRAME), .MIN_CYCLES(MINC),
                   .CYC_PER_DEG(CPD), .MAX_ANGLE(MAXA), .RESET_ANGLE(RSTA), .SLEW_DEG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready0),
    .wr_ch(wr_ch), .wr_angle(wr_angle), .servo_out(so0), .frame_tick(ft0), .sat_err(se0));

  servo_pwm_bank #(.N_CH(N_CH), .ANGLE_W(8), .FRAME_CYCLES(FRAME), .MIN_CYCLES(MINC),
                   .CYC_PER_DEG(CPD), .MAX_ANGLE(MAXA), .RESET_ANGLE(RSTA), .SLEW_DEG(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_valid(wr_valid), .wr_ready(wr_ready1),
    .wr_ch(wr_ch), .wr_angle(wr_angle), .servo_out(so1), .frame_tick(ft1), .sat_err(se1));

  int checks = 0;
  int errors = 0;

  // Model state: index 0 = unlimited slew, 1 = slew of 10 degrees/frame.
  int slew_lim[2] = '{0, 10};
  int tgt[2][N_CH], act[2][N_CH], wreg[2][N_CH], wframe[2][N_CH];
  int hi[2][N_CH], meas[2][N_CH];
  int tb_cnt, cyc, frames_done;
  bit frame_ok, rdy_m, sat_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int slew_to(input int t, input int a, input int lim);
    int d;
    d = t - a;
    if (lim != 0) begin
      if (d > lim)  d = lim;
      if (d < -lim) d = -lim;
    end
    return a + d;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N_CH; i++) begin
        tgt[d][i]  = RSTA;
        act[d][i]  = RSTA;
        wreg[d][i] = MINC + RSTA * CPD;
      end
    tb_cnt = 0; frame_ok = 0; rdy_m = 0; sat_m = 0;
  endtask

  // One clock: check ready, advance the model across the edge, then sample outputs.
  task automatic step();
    bit exp_rdy, acc, en_s;
    int c_s, ch_s, a_s;
    logic [N_CH-1:0] so_d;
    exp_rdy = rdy_m && !(enable && tb_cnt == FRAME - 2);
    check("wr_ready0", wr_ready0, exp_rdy);
    check("wr_ready1", wr_ready1, exp_rdy);
    acc  = wr_valid && exp_rdy;
    en_s = enable; c_s = tb_cnt; ch_s = wr_ch; a_s = wr_angle;
    @(posedge clk);
    rdy_m = 1;
    for (int d = 0; d < 2; d++) begin
      if (acc) tgt[d][ch_s] = (a_s > MAXA) ? MAXA : a_s;
      for (int i = 0; i < N_CH; i++) begin
        if (en_s && c_s == FRAME - 2) act[d][i] = slew_to(tgt[d][i], act[d][i], slew_lim[d]);
        if (en_s && c_s == FRAME - 1) wreg[d][i] = MINC + act[d][i] * CPD;
      end
    end
    if (acc && a_s > MAXA) sat_m = 1;
    tb_cnt = en_s ? ((c_s == FRAME - 1) ? 0 : c_s + 1) : 0;
    #1;
    if (!en_s) begin
      check("off_out0", so0, 0);
      check("off_out1", so1, 0);
      check("off_tick", ft0, 0);
      frame_ok = 0;
    end else begin
      check("frame_tick0", ft0, c_s == 0);
      check("frame_tick1", ft1, c_s == 0);
      if (c_s == 0) begin
        if (frame_ok) begin
          check("frame_period", cyc, FRAME);
          check("sat_err0", se0, sat_m);
          check("sat_err1", se1, sat_m);
          for (int d = 0; d < 2; d++)
            for (int i = 0; i < N_CH; i++) begin
              check($sformatf("width_d%0d_ch%0d", d, i), hi[d][i], wframe[d][i]);
              meas[d][i] = hi[d][i];
            end
          frames_done++;
        end
        frame_ok = 1;
        cyc = 0;
        for (int d = 0; d < 2; d++)
          for (int i = 0; i < N_CH; i++) begin
            hi[d][i] = 0;
            wframe[d][i] = wreg[d][i];
          end
      end
      cyc++;
      for (int d = 0; d < 2; d++) begin
        so_d = (d == 0) ? so0 : so1;
        for (int i = 0; i < N_CH; i++) hi[d][i] += int'(so_d[i]);
      end
    end
  endtask

  task automatic wait_frame();
    int f0, n;
    f0 = frames_done; n = 0;
    while (frames_done == f0 && n < 2 * FRAME + 10) begin
      step(); n++;
    end
    check("frame_done_in_time", frames_done != f0, 1);
  endtask

  task automatic run_to(input int c);
    int n;
    n = 0;
    while (tb_cnt != c && n < 2 * FRAME) begin
      step(); n++;
    end
    check("reach_cnt", tb_cnt, c);
  endtask

  task automatic wr(input int ch, input int ang);
    wr_valid = 1; wr_ch = 2'(ch); wr_angle = 8'(ang);
    step();
    wr_valid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1; enable = 0; wr_valid = 0; wr_ch = 0; wr_angle = 0;
    frames_done = 0; cyc = 0;
    model_reset();
    #1 rst_n = 0;
    #1;
    check("rst_out0", so0, 0);
    check("rst_tick", ft0, 0);
    check("rst_ready", wr_ready0, 0);
    check("rst_sat", se0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1; enable = 1;

    // 1: reset widths on every channel
    wait_frame();
    wait_frame();
    for (int i = 0; i < N_CH; i++) check("t1_width", meas[0][i], 950);
    check("t1_sat", se0, 0);

    // 4: slew-limited descent from 90 to 0
    run_to(100);
    wr(0, 0);
    wait_frame();
    check("t4_inprogress", meas[1][0], 950);
    for (int k = 1; k <= 10; k++) begin
      wait_frame();
      check($sformatf("t4_slew_f%0d", k), meas[1][0], (950 - 50 * k < 500) ? 500 : 950 - 50 * k);
      if (k == 1) check("t4_unlimited", meas[0][0], 500);
    end

    // 2: mid-frame write never touches the frame in progress
    run_to(300);
    wr(2, 0);
    wait_frame();
    check("t2_cur", meas[0][2], 950);
    wait_frame();
    check("t2_next", meas[0][2], 500);
    check("t2_ch1", meas[0][1], 950);
    check("t2_ch3", meas[0][3], 950);

    // 3: clamped write sets sticky sat_err
    run_to(300);
    wr(1, 200);
    check("t3_sat0", se0, 1);
    check("t3_sat1", se1, 1);
    wait_frame();
    wait_frame();
    check("t3_clamped", meas[0][1], 1400);
    run_to(50);
    wr(3, 100);
    check("t3_sticky", se0, 1);
    wait_frame();

    // 5: write held across the refused cycle
    run_to(FRAME - 2);
    wr_valid = 1; wr_ch = 2'd3; wr_angle = 8'd20;
    check("t5_ready_low", wr_ready0, 0);
    step();
    check("t5_ready_back", wr_ready0, 1);
    step();
    wr_valid = 0;
    wait_frame();
    wait_frame();
    check("t5_after_next_old", meas[0][3], 1000);
    wait_frame();
    check("t5_new", meas[0][3], 600);

    // 6: disable mid-pulse, write while disabled, restart
    run_to(200);
    enable = 0;
    step();
    check("t6_off", so0, 0);
    wr(2, 40);
    repeat (3) step();
    enable = 1;
    step();
    check("t6_restart_tick", ft0, 1);
    check("t6_restart_out", so0, 4'hF);
    wait_frame();
    check("t6_restart_width", meas[0][2], 500);
    wait_frame();
    check("t6_commit", meas[0][2], 700);

    // reset mid-pulse drops outputs at once and discards pending targets
    run_to(50);
    wr(3, 180);
    run_to(100);
    #2 rst_n = 0;
    #1;
    check("rst_mid_out0", so0, 0);
    check("rst_mid_out1", so1, 0);
    check("rst_mid_sat", se0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    wait_frame();
    check("rst_ch3", meas[0][3], 950);
    check("rst_slew_ch0", meas[1][0], 950);
    check("rst_sat_after", se0, 0);

    // random writes checked frame by frame against the model
    for (int k = 0; k < 5 * FRAME; k++) begin
      wr_valid = ($urandom_range(0, 39) == 0);
      wr_ch    = 2'($urandom_range(0, 3));
      wr_angle = 8'($urandom_range(0, 255));
      step();
    end
    wr_valid = 0;
    wait_frame();
    wait_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
